pipe_hazard_ctrl: RTL and testbench

- Pipeline control unit for the 5-stage SIMD AES core.
- Detects load-use hazards between the ID and EX stages and holds the front end while a multi-cycle vector AES operation occupies EX.
- Squashes wrong-path instructions on a taken branch.
- Drives the stall and flush/bubble controls of the PC, IF/ID and ID/EX pipeline registers.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/hazard_cmp.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the SIMD AES pipeline hazard control unit.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {RUN, LOAD_STALL, VEC_WAIT} hz_state_t;

    // EX writeback select encoding that marks a load.
    localparam logic [1:0] MTR_LOAD = 2'b01;

    // Wide enough for the vector occupancy counter (VEC_LAT up to 15).
    localparam int VCNT_W = 4;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic vreg_write;
    } ex_ctrl_t;

    // Controls loaded into ID/EX when a bubble is inserted.
    localparam ex_ctrl_t NOP_CTRL = '{reg_write: 1'b0, mem_write: 1'b0, vreg_write: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard control unit (slave).
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs2;
    logic             id_is_vec;
    logic [REG_W-1:0] ex_rd;
    logic [1:0]       ex_mem_to_reg;
    logic             ex_reg_write;
    logic             ex_vreg_write;
    logic             ex_vec_start;
    logic             vec_done;
    logic             branch_taken;

    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             vec_busy;
    logic             vec_timeout;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, id_is_vec, ex_rd, ex_mem_to_reg,
               ex_reg_write, ex_vreg_write, ex_vec_start, vec_done, branch_taken,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, vec_busy,
               vec_timeout, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, id_is_vec, ex_rd, ex_mem_to_reg,
               ex_reg_write, ex_vreg_write, ex_vec_start, vec_done, branch_taken,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, vec_busy,
               vec_timeout, stall_count
    );
endinterface

// File: rtl/hazard_cmp.sv
// Combinational load-use hazard comparator between the ID and EX stages;
// also usable by the forwarding unit.
module hazard_cmp
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic             id_is_vec,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [1:0]       ex_mem_to_reg,
    input  logic             ex_reg_write,
    input  logic             ex_vreg_write,
    output logic             luh
);
    logic dst_live;
    logic src_match;

    always_comb begin
        // Scalar x0 is hardwired zero; vector v0 is a real register.
        dst_live  = (ex_reg_write && !id_is_vec && (ex_rd != '0)) ||
                    (ex_vreg_write && id_is_vec);
        src_match = (ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2));
        luh       = (ex_mem_to_reg == MTR_LOAD) && dst_live && src_match;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: load-use stall, vector-op hold with timeout, branch squash.
// Define HAZARD_PERF_CNT_EN to implement the stall performance counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int VEC_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_hazard_ctrl_if.slave   bus
);
    hz_state_t         state_q, state_d;
    logic [VCNT_W-1:0] vcnt_q, vcnt_d;
    logic              timeout_q, timeout_d;
    logic              luh;

    hazard_cmp #(.REG_W(REG_W)) u_hazard_cmp (
        .id_rs1        (bus.id_rs1),
        .id_rs2        (bus.id_rs2),
        .id_uses_rs2   (bus.id_uses_rs2),
        .id_is_vec     (bus.id_is_vec),
        .ex_rd         (bus.ex_rd),
        .ex_mem_to_reg (bus.ex_mem_to_reg),
        .ex_reg_write  (bus.ex_reg_write),
        .ex_vreg_write (bus.ex_vreg_write),
        .luh           (luh)
    );

    always_comb begin
        // NOTE: every output and next-state gets a default first so no latch is inferred.
        state_d          = state_q;
        vcnt_d           = vcnt_q;
        timeout_d        = timeout_q;
        bus.pc_stall     = 1'b0;
        bus.if_id_stall  = 1'b0;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_bubble = 1'b0;
        bus.vec_busy     = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.ex_vec_start) begin
                    state_d         = VEC_WAIT;
                    vcnt_d          = VCNT_W'(VEC_LAT - 1);
                    bus.pc_stall    = 1'b1;
                    bus.if_id_stall = 1'b1;
                end else if (bus.branch_taken) begin
                    bus.if_id_flush  = 1'b1;
                    bus.id_ex_bubble = 1'b1;
                end else if (luh) begin
                    state_d          = LOAD_STALL;
                    bus.pc_stall     = 1'b1;
                    bus.if_id_stall  = 1'b1;
                    bus.id_ex_bubble = 1'b1;
                end
            end
            // Load now sits in MEM; forwarding covers the dependency.
            LOAD_STALL: state_d = RUN;
            VEC_WAIT: begin
                bus.vec_busy = 1'b1;
                if (bus.vec_done) begin
                    state_d = RUN;
                end else begin
                    bus.pc_stall    = 1'b1;
                    bus.if_id_stall = 1'b1;
                    if (vcnt_q == '0) begin
                        timeout_d = 1'b1;
                        state_d   = RUN;
                    end else begin
                        vcnt_d = vcnt_q - 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q   <= RUN;
            vcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vcnt_q    <= vcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.vec_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of PC-stall cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_count = stall_cnt_q;
`else
    assign bus.stall_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: reference model feeds a scoreboard queue
// that is compared against the DUT outputs every cycle.
module tb_pipe_hazard_ctrl;
    localparam int REG_W   = 5;
    localparam int VEC_LAT = 4;
    localparam int CNT_W   = 4;
    localparam int SC_MAX  = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    typedef struct packed {
        logic             pc_stall;
        logic             if_id_stall;
        logic             if_id_flush;
        logic             id_ex_bubble;
        logic             vec_busy;
        logic             vec_timeout;
        logic [CNT_W-1:0] stall_count;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];

    // Model state: 0 = RUN, 1 = LOAD_STALL, 2 = VEC_WAIT
    int   m_state, n_state;
    int   m_wait, n_wait;
    logic m_to, n_to;
    int   m_sc, n_sc;

    pipe_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.REG_W(REG_W), .VEC_LAT(VEC_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                         input logic iv, input logic [4:0] rd, input logic [1:0] mtr,
                         input logic rw, input logic vrw, input logic vs, input logic vd,
                         input logic br);
        bus.id_rs1        = rs1;
        bus.id_rs2        = rs2;
        bus.id_uses_rs2   = u2;
        bus.id_is_vec     = iv;
        bus.ex_rd         = rd;
        bus.ex_mem_to_reg = mtr;
        bus.ex_reg_write  = rw;
        bus.ex_vreg_write = vrw;
        bus.ex_vec_start  = vs;
        bus.vec_done      = vd;
        bus.branch_taken  = br;
    endtask

    task automatic idle();
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_wait  = 0;
        m_to    = 1'b0;
        m_sc    = 0;
    endtask

    function automatic logic model_luh();
        logic live;
        logic hit;
        live = (bus.ex_reg_write && !bus.id_is_vec && bus.ex_rd != 5'd0) ||
               (bus.ex_vreg_write && bus.id_is_vec);
        hit  = (bus.ex_rd == bus.id_rs1) || (bus.id_uses_rs2 && bus.ex_rd == bus.id_rs2);
        return (bus.ex_mem_to_reg == 2'b01) && live && hit;
    endfunction

    task automatic predict(output exp_t e);
        logic ps, is, fl, bb;
        ps = 1'b0; is = 1'b0; fl = 1'b0; bb = 1'b0;
        n_state = m_state;
        n_wait  = m_wait;
        n_to    = m_to;
        if (m_state == 0) begin
            if (bus.ex_vec_start) begin
                ps = 1'b1; is = 1'b1; n_state = 2; n_wait = 0;
            end else if (bus.branch_taken) begin
                fl = 1'b1; bb = 1'b1;
            end else if (model_luh()) begin
                ps = 1'b1; is = 1'b1; bb = 1'b1; n_state = 1;
            end
        end else if (m_state == 1) begin
            n_state = 0;
        end else begin
            if (bus.vec_done) begin
                n_state = 0;
            end else begin
                ps = 1'b1; is = 1'b1;
                if (m_wait == VEC_LAT - 1) begin
                    n_to = 1'b1; n_state = 0;
                end else begin
                    n_wait = m_wait + 1;
                end
            end
        end
        n_sc = (ps && m_sc < SC_MAX) ? m_sc + 1 : m_sc;
        e.pc_stall     = ps;
        e.if_id_stall  = is;
        e.if_id_flush  = fl;
        e.id_ex_bubble = bb;
        e.vec_busy     = (m_state == 2);
        e.vec_timeout  = m_to;
        e.stall_count  = CNT_W'(m_sc * PERF);
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step(input string tag);
        exp_t e;
        predict(e);
        exp_q.push_back(e);
        #2;
        e = exp_q.pop_front();
        check({tag, ".pc_stall"},     32'(bus.pc_stall),     32'(e.pc_stall));
        check({tag, ".if_id_stall"},  32'(bus.if_id_stall),  32'(e.if_id_stall));
        check({tag, ".if_id_flush"},  32'(bus.if_id_flush),  32'(e.if_id_flush));
        check({tag, ".id_ex_bubble"}, 32'(bus.id_ex_bubble), 32'(e.id_ex_bubble));
        check({tag, ".vec_busy"},     32'(bus.vec_busy),     32'(e.vec_busy));
        check({tag, ".vec_timeout"},  32'(bus.vec_timeout),  32'(e.vec_timeout));
        check({tag, ".stall_count"},  32'(bus.stall_count),  32'(e.stall_count));
        @(posedge clk);
        m_state = n_state;
        m_wait  = n_wait;
        m_to    = n_to;
        m_sc    = n_sc;
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step("reset");

        // Scalar load-use on x5 via rs1
        drive(5'd5, 5'd7, 1'b0, 1'b0, 5'd5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("luh_c0");
        step("luh_c1");
        check("luh_cnt", 32'(bus.stall_count), 32'(PERF * 1));

        // x0 destination never stalls
        drive(5'd0, 5'd7, 1'b0, 1'b0, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ld_x0");
        // rs2 match ignored when rs2 is unused
        drive(5'd3, 5'd9, 1'b0, 1'b0, 5'd9, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rs2_unused");
        // Scalar write does not hazard a vector reader
        drive(5'd9, 5'd1, 1'b0, 1'b1, 5'd9, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("vec_vs_scalar");
        // Vector load into v0 read through rs2
        drive(5'd3, 5'd0, 1'b1, 1'b1, 5'd0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("vld_v0_c0");
        idle();
        step("vld_v0_c1");

        // Vector op finishing in its third wait cycle
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("vdone_start");
        idle();
        step("vdone_w0");
        bus.branch_taken = 1'b1;
        step("vdone_w1_br");
        bus.branch_taken = 1'b0;
        bus.vec_done = 1'b1;
        step("vdone_w2");
        idle();
        step("vdone_run");
        check("vdone_cnt", 32'(bus.stall_count), 32'(PERF * 5));

        // Branch outranks a simultaneous load-use hazard
        drive(5'd5, 5'd7, 1'b0, 1'b0, 5'd5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("br_luh");
        bus.branch_taken = 1'b0;
        step("br_then_luh");
        idle();
        step("br_then_ls");

        // Vector op with no vec_done: four busy cycles then sticky timeout
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("to_start");
        idle();
        for (int i = 0; i < VEC_LAT; i++) step($sformatf("to_w%0d", i));
        step("to_run0");
        step("to_run1");
        check("to_sticky", 32'(bus.vec_timeout), 32'd1);

        // Asynchronous reset during VEC_WAIT
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("rst_start");
        idle();
        step("rst_w0");
        #2 rst_n = 1'b0;
        #1;
        check("rst_async.pc_stall",    32'(bus.pc_stall),    32'd0);
        check("rst_async.if_id_stall", 32'(bus.if_id_stall), 32'd0);
        check("rst_async.vec_busy",    32'(bus.vec_busy),    32'd0);
        check("rst_async.vec_timeout", 32'(bus.vec_timeout), 32'd0);
        check("rst_async.stall_count", 32'(bus.stall_count), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("post_rst_start");
        idle();
        step("post_rst_w0");
        bus.vec_done = 1'b1;
        step("post_rst_w1");
        idle();
        step("post_rst_run");

        // Drive enough load-use stalls to saturate the counter
        for (int i = 0; i < 20; i++) begin
            drive(5'd6, 5'd7, 1'b0, 1'b0, 5'd6, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step($sformatf("sat_luh%0d", i));
            idle();
            step($sformatf("sat_ls%0d", i));
        end
        check("sat_cnt", 32'(bus.stall_count), 32'(PERF * SC_MAX));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
